lcd_capture: RTL and testbench

LCD_CAPTURE -- requirements
Module: lcd_capture

---
 rtl/lcd_capture.sv | 240 ++++++++++++++++++++++++
 tb/tb_lcd_capture.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_capture.sv
`default_nettype none
// lcd_capture: parallel RGB LCD capture with per-line/per-frame timing checks and lock detection.
// Optional macro LCD_CAPTURE_CRC_EN adds frame_crc (CRC-16-CCITT of every captured pixel per frame).
module lcd_capture #(
    parameter int H_LINE = 480,
    parameter int V_LINE = 272
) (
    input  logic        clk,
    input  logic        rest_n,
    input  logic        lcd_hsync,
    input  logic        lcd_vsync,
    input  logic        lcd_de,
    input  logic [7:0]  lcd_r,
    input  logic [7:0]  lcd_g,
    input  logic [7:0]  lcd_b,
    output logic        pix_valid,
    output logic [23:0] pix_data,
    output logic [10:0] pix_x,
    output logic [10:0] pix_y,
    output logic        frame_start,
    output logic        line_done,
    output logic        frame_done,
    output logic        err_hlen,
    output logic        err_vlen,
    output logic        locked
`ifdef LCD_CAPTURE_CRC_EN
    ,
    output logic [15:0] frame_crc
`endif
);

    typedef enum logic [0:0] {SEARCH = 1'b0, FRAME = 1'b1} state_t;

    localparam logic [10:0] H_LINE_C = 11'(H_LINE);
    localparam logic [10:0] V_LINE_C = 11'(V_LINE);
    localparam logic [10:0] CNT_MAX  = 11'h7FF;

    // stage-1 input registers and their one-cycle history for edge detection
    logic        hs_q, vs_q, de_q, vs_prev_q, de_prev_q;
    logic [23:0] rgb_q;

    state_t      state_q, state_d;
    logic [10:0] pix_cnt_q, pix_cnt_d, line_cnt_q, line_cnt_d;
    logic        drop_q, drop_d, frame_err_q, frame_err_d;
    logic [1:0]  clean_q, clean_d;
    logic        locked_q, locked_d;
    logic        pix_valid_q, pix_valid_d;
    logic [23:0] pix_data_q, pix_data_d;
    logic [10:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic        frame_start_q, frame_start_d, line_done_q, line_done_d;
    logic        frame_done_q, frame_done_d, err_hlen_q, err_hlen_d, err_vlen_q, err_vlen_d;

    logic        w_vs_fall;
    logic [10:0] w_pix_inc, w_line_inc, w_line_eff;
    logic        w_frame_clean;

`ifdef LCD_CAPTURE_CRC_EN
    logic [15:0] crc_acc_q, crc_acc_d, frame_crc_q, frame_crc_d;

    function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic [23:0] data);
        logic [15:0] c;
        logic        fb;
        c = crc;
        for (int i = 23; i >= 0; i--) begin
            fb = c[15] ^ data[i];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return c;
    endfunction
`endif

    assign w_vs_fall  = vs_prev_q & ~vs_q;
    assign w_pix_inc  = (pix_cnt_q == CNT_MAX) ? pix_cnt_q : pix_cnt_q + 11'd1;
    assign w_line_inc = (line_cnt_q == CNT_MAX) ? line_cnt_q : line_cnt_q + 11'd1;

    always_comb begin
        state_d       = state_q;
        pix_cnt_d     = pix_cnt_q;
        line_cnt_d    = line_cnt_q;
        drop_d        = drop_q;
        frame_err_d   = frame_err_q;
        clean_d       = clean_q;
        locked_d      = locked_q;
        pix_valid_d   = 1'b0;
        pix_data_d    = pix_data_q;
        pix_x_d       = pix_x_q;
        pix_y_d       = pix_y_q;
        frame_start_d = 1'b0;
        line_done_d   = 1'b0;
        frame_done_d  = 1'b0;
        err_hlen_d    = 1'b0;
        err_vlen_d    = 1'b0;
        w_line_eff    = line_cnt_q;
        w_frame_clean = 1'b0;
`ifdef LCD_CAPTURE_CRC_EN
        crc_acc_d     = crc_acc_q;
        frame_crc_d   = frame_crc_q;
`endif

        if (state_q == FRAME) begin
            if (de_q) begin
                if (!vs_q) begin
                    // active data inside the vsync pulse: discard, flag once per line
                    err_vlen_d = ~drop_q;
                    drop_d     = 1'b1;
                end else begin
                    pix_valid_d = 1'b1;
                    pix_data_d  = rgb_q;
                    pix_x_d     = pix_cnt_q;
                    pix_y_d     = line_cnt_q;
                    pix_cnt_d   = w_pix_inc;
                    err_hlen_d  = ~hs_q;
`ifdef LCD_CAPTURE_CRC_EN
                    crc_acc_d   = crc_step(crc_acc_q, rgb_q);
`endif
                end
            end else if (de_prev_q) begin
                pix_cnt_d = 11'd0;
                drop_d    = 1'b0;
                if (!drop_q) begin
                    line_done_d = 1'b1;
                    err_hlen_d  = (pix_cnt_q != H_LINE_C);
                    line_cnt_d  = w_line_inc;
                    w_line_eff  = w_line_inc;
                    if (w_line_inc == V_LINE_C) begin
                        frame_done_d = 1'b1;
`ifdef LCD_CAPTURE_CRC_EN
                        frame_crc_d  = crc_acc_q;
`endif
                    end
                end
            end
        end

        // frame boundary is evaluated after the line close so it sees the updated count
        if (w_vs_fall) begin
            frame_start_d = 1'b1;
            state_d       = FRAME;
            line_cnt_d    = 11'd0;
            pix_cnt_d     = 11'd0;
            pix_y_d       = 11'd0;
`ifdef LCD_CAPTURE_CRC_EN
            crc_acc_d     = 16'hFFFF;
`endif
            if (state_q == FRAME) begin
                err_vlen_d    = err_vlen_d | (w_line_eff != V_LINE_C);
                w_frame_clean = ~frame_err_q & ~err_hlen_d & ~err_vlen_d;
                if (w_frame_clean) begin
                    clean_d = (clean_q == 2'd2) ? 2'd2 : clean_q + 2'd1;
                    if (clean_q != 2'd0) begin
                        locked_d = 1'b1;
                    end
                end
            end
            frame_err_d = 1'b0;
        end

        if (err_hlen_d || err_vlen_d) begin
            locked_d = 1'b0;
            clean_d  = 2'd0;
            if (!w_vs_fall) begin
                frame_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rest_n) begin
        if (!rest_n) begin
            hs_q          <= 1'b0;
            vs_q          <= 1'b0;
            de_q          <= 1'b0;
            vs_prev_q     <= 1'b0;
            de_prev_q     <= 1'b0;
            rgb_q         <= 24'd0;
            state_q       <= SEARCH;
            pix_cnt_q     <= 11'd0;
            line_cnt_q    <= 11'd0;
            drop_q        <= 1'b0;
            frame_err_q   <= 1'b0;
            clean_q       <= 2'd0;
            locked_q      <= 1'b0;
            pix_valid_q   <= 1'b0;
            pix_data_q    <= 24'd0;
            pix_x_q       <= 11'd0;
            pix_y_q       <= 11'd0;
            frame_start_q <= 1'b0;
            line_done_q   <= 1'b0;
            frame_done_q  <= 1'b0;
            err_hlen_q    <= 1'b0;
            err_vlen_q    <= 1'b0;
`ifdef LCD_CAPTURE_CRC_EN
            crc_acc_q     <= 16'hFFFF;
            frame_crc_q   <= 16'd0;
`endif
        end else begin
            hs_q          <= lcd_hsync;
            vs_q          <= lcd_vsync;
            de_q          <= lcd_de;
            vs_prev_q     <= vs_q;
            de_prev_q     <= de_q;
            rgb_q         <= {lcd_r, lcd_g, lcd_b};
            state_q       <= state_d;
            pix_cnt_q     <= pix_cnt_d;
            line_cnt_q    <= line_cnt_d;
            drop_q        <= drop_d;
            frame_err_q   <= frame_err_d;
            clean_q       <= clean_d;
            locked_q      <= locked_d;
            pix_valid_q   <= pix_valid_d;
            pix_data_q    <= pix_data_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            frame_start_q <= frame_start_d;
            line_done_q   <= line_done_d;
            frame_done_q  <= frame_done_d;
            err_hlen_q    <= err_hlen_d;
            err_vlen_q    <= err_vlen_d;
`ifdef LCD_CAPTURE_CRC_EN
            crc_acc_q     <= crc_acc_d;
            frame_crc_q   <= frame_crc_d;
`endif
        end
    end

    assign pix_valid   = pix_valid_q;
    assign pix_data    = pix_data_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign frame_start = frame_start_q;
    assign line_done   = line_done_q;
    assign frame_done  = frame_done_q;
    assign err_hlen    = err_hlen_q;
    assign err_vlen    = err_vlen_q;
    assign locked      = locked_q;
`ifdef LCD_CAPTURE_CRC_EN
    assign frame_crc   = frame_crc_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lcd_capture.sv
`default_nettype none
// Scoreboard bench for lcd_capture on a reduced 8x6 raster; define LCD_CAPTURE_CRC_EN to cover frame_crc.
module tb_lcd_capture;

    localparam int H = 8;
    localparam int V = 6;

    logic        clk = 1'b0;
    logic        rest_n = 1'b0;
    logic        lcd_hsync = 1'b1, lcd_vsync = 1'b1, lcd_de = 1'b0;
    logic [7:0]  lcd_r = 8'd0, lcd_g = 8'd0, lcd_b = 8'd0;
    logic        pix_valid, frame_start, line_done, frame_done, err_hlen, err_vlen, locked;
    logic [23:0] pix_data;
    logic [10:0] pix_x, pix_y;
`ifdef LCD_CAPTURE_CRC_EN
    logic [15:0] frame_crc;
`endif

    lcd_capture #(.H_LINE(H), .V_LINE(V)) dut (
        .clk(clk), .rest_n(rest_n),
        .lcd_hsync(lcd_hsync), .lcd_vsync(lcd_vsync), .lcd_de(lcd_de),
        .lcd_r(lcd_r), .lcd_g(lcd_g), .lcd_b(lcd_b),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y),
        .frame_start(frame_start), .line_done(line_done), .frame_done(frame_done),
        .err_hlen(err_hlen), .err_vlen(err_vlen), .locked(locked)
`ifdef LCD_CAPTURE_CRC_EN
        , .frame_crc(frame_crc)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pv;
        logic [10:0] x;
        logic [10:0] y;
        logic [23:0] d;
        logic        ld, fd, fs, eh, ev, lk;
        logic [15:0] crc;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  failures = 0;

    // reference state for lock and CRC expectations
    int          clean_cnt = 0;
    bit          exp_locked = 1'b0;
    bit          frame_err = 1'b0;
    bit          in_frame = 1'b0;
    logic [15:0] crc_acc = 16'hFFFF;

    function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic [23:0] data);
        logic [15:0] c;
        logic        fb;
        c = crc;
        for (int i = 23; i >= 0; i--) begin
            fb = c[15] ^ data[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic ev_t blank();
        ev_t e;
        e.pv = 1'b0; e.x = 11'd0; e.y = 11'd0; e.d = 24'd0;
        e.ld = 1'b0; e.fd = 1'b0; e.fs = 1'b0; e.eh = 1'b0; e.ev = 1'b0; e.lk = 1'b0;
        e.crc = 16'd0;
        return e;
    endfunction

    task automatic push(input ev_t e);
        e.lk = exp_locked;
        exp_q.push_back(e);
    endtask

    task automatic note_err();
        exp_locked = 1'b0;
        clean_cnt  = 0;
        frame_err  = 1'b1;
    endtask

    task automatic fs_model(inout ev_t e, input int lines);
        e.fs = 1'b1;
        if (in_frame) begin
            e.ev = (lines != V);
            if (e.ev) note_err();
            if (!frame_err) begin
                clean_cnt = (clean_cnt >= 2) ? 2 : clean_cnt + 1;
                if (clean_cnt == 2) exp_locked = 1'b1;
            end else begin
                clean_cnt  = 0;
                exp_locked = 1'b0;
            end
        end
        frame_err = 1'b0;
        in_frame  = 1'b1;
        crc_acc   = 16'hFFFF;
    endtask

    task automatic drv(input logic vs, input logic hs, input logic de, input logic [23:0] rgb);
        @(negedge clk);
        lcd_vsync = vs;
        lcd_hsync = hs;
        lcd_de    = de;
        {lcd_r, lcd_g, lcd_b} = rgb;
    endtask

    task automatic pixel_line(input int n, input int y, input bit zero, input int hs_bad);
        ev_t         e;
        logic [23:0] rgb;
        for (int i = 0; i < n; i++) begin
            rgb = zero ? 24'h000000 : {8'(y), 8'(i), 8'hA5};
            drv(1'b1, (i == hs_bad) ? 1'b0 : 1'b1, 1'b1, rgb);
            e = blank();
            e.pv = 1'b1; e.x = 11'(i); e.y = 11'(y); e.d = rgb;
            if (i == hs_bad) begin
                e.eh = 1'b1;
                note_err();
            end
            crc_acc = crc_step(crc_acc, rgb);
            push(e);
        end
    endtask

    task automatic close_line(input int n, input int y, input bit with_vs);
        ev_t e;
        drv(with_vs ? 1'b0 : 1'b1, 1'b1, 1'b0, 24'd0);
        e = blank();
        e.ld = 1'b1;
        e.eh = (n != H);
        if (e.eh) note_err();
        e.fd  = ((y + 1) == V);
        e.crc = crc_acc;
        if (with_vs) fs_model(e, y + 1);
        push(e);
    endtask

    task automatic vs_pulse(input int lines);
        ev_t e;
        drv(1'b0, 1'b1, 1'b0, 24'd0);
        e = blank();
        fs_model(e, lines);
        push(e);
        drv(1'b0, 1'b1, 1'b0, 24'd0);
        drv(1'b1, 1'b1, 1'b0, 24'd0);
        drv(1'b1, 1'b1, 1'b0, 24'd0);
    endtask

    task automatic frame_lines(input int nlines, input int short_y, input int hs_bad_y,
                               input bit zero, input bit last_vs);
        int n;
        bit lv;
        for (int y = 0; y < nlines; y++) begin
            n  = (y == short_y) ? H - 1 : H;
            pixel_line(n, y, zero, (y == hs_bad_y) ? 3 : -1);
            lv = last_vs && (y == nlines - 1);
            close_line(n, y, lv);
            if (!lv) begin
                drv(1'b1, 1'b0, 1'b0, 24'd0);
                drv(1'b1, 1'b1, 1'b0, 24'd0);
                drv(1'b1, 1'b1, 1'b0, 24'd0);
            end
        end
    endtask

    // monitor: every cycle with any output activity must match the next expected event
    ev_t m_e;
    always @(negedge clk) begin
        if (rest_n && (pix_valid || line_done || frame_done || frame_start || err_hlen || err_vlen)) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output pv=%b ld=%b fd=%b fs=%b eh=%b ev=%b required=none at %0t",
                         pix_valid, line_done, frame_done, frame_start, err_hlen, err_vlen, $time);
            end else begin
                m_e = exp_q.pop_front();
                chk("flags{pv,ld,fd,fs,eh,ev,lk}",
                    {25'd0, pix_valid, line_done, frame_done, frame_start, err_hlen, err_vlen, locked},
                    {25'd0, m_e.pv, m_e.ld, m_e.fd, m_e.fs, m_e.eh, m_e.ev, m_e.lk});
                if (m_e.pv) begin
                    chk("pix_x", 32'(pix_x), 32'(m_e.x));
                    chk("pix_y", 32'(pix_y), 32'(m_e.y));
                    chk("pix_data", 32'(pix_data), 32'(m_e.d));
                end
`ifdef LCD_CAPTURE_CRC_EN
                if (m_e.fd) chk("frame_crc", 32'(frame_crc), 32'(m_e.crc));
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_pix_valid", 32'(pix_valid), 32'd0);
        chk("rst_pulses", {26'd0, frame_start, line_done, frame_done, err_hlen, err_vlen, locked}, 32'd0);
        chk("rst_pix_xy", {10'd0, pix_x, pix_y}, 32'd0);
        chk("rst_pix_data", 32'(pix_data), 32'd0);
`ifdef LCD_CAPTURE_CRC_EN
        chk("rst_frame_crc", 32'(frame_crc), 32'd0);
`endif

        // reset released in the middle of an active line: rest of frame must stay silent
        for (int i = 0; i < 4; i++) drv(1'b1, 1'b1, 1'b1, 24'h123456);
        rest_n = 1'b1;
        for (int i = 0; i < 4; i++) drv(1'b1, 1'b1, 1'b1, 24'h654321);
        drv(1'b1, 1'b1, 1'b0, 24'd0);
        for (int l = 0; l < 2; l++) begin
            for (int i = 0; i < H; i++) drv(1'b1, 1'b1, 1'b1, 24'hABCDEF);
            drv(1'b1, 1'b0, 1'b0, 24'd0);
            drv(1'b1, 1'b1, 1'b0, 24'd0);
        end

        vs_pulse(0);                                 // A: first frame, no vlen check
        frame_lines(V, -1, -1, 1'b0, 1'b0);
        vs_pulse(V);                                 // B
        frame_lines(V, -1, -1, 1'b0, 1'b0);
        vs_pulse(V);                                 // C: locked rises here
        frame_lines(V, 2, -1, 1'b0, 1'b0);           // short line 2 drops lock
        vs_pulse(V);                                 // D
        frame_lines(V - 1, -1, -1, 1'b0, 1'b0);      // one line missing
        vs_pulse(V - 1);                             // E: err_vlen with frame_start
        frame_lines(V, -1, -1, 1'b1, 1'b1);          // all-zero frame, last DE fall with vsync fall

        // F: DE asserted while vsync is still low, then hsync-low during DE on line 0
        begin
            ev_t e;
            drv(1'b0, 1'b1, 1'b1, 24'h111111);
            e = blank();
            e.ev = 1'b1;
            note_err();
            push(e);
            drv(1'b0, 1'b1, 1'b1, 24'h222222);
            drv(1'b0, 1'b1, 1'b1, 24'h333333);
            drv(1'b0, 1'b1, 1'b0, 24'd0);
            drv(1'b1, 1'b1, 1'b0, 24'd0);
            drv(1'b1, 1'b1, 1'b0, 24'd0);
        end
        frame_lines(V, -1, 0, 1'b0, 1'b0);
        vs_pulse(V);

        repeat (6) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        // asynchronous reset while pixels are streaming
        pixel_line(6, 0, 1'b0, -1);
        #2;
        chk("pre_rst_pix_valid", 32'(pix_valid), 32'd1);
        rest_n = 1'b0;
        #1;
        chk("async_rst_pix_valid", 32'(pix_valid), 32'd0);
        chk("async_rst_pix_x", 32'(pix_x), 32'd0);
        chk("async_rst_pix_data", 32'(pix_data), 32'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
